bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Parametrised successor to the two-port fetch/memory bus interface. It arbitrates `CHANNELS` pipeline requesters (fetch, memory, future DMA/debug) onto one word-wide system bus, using fixed or round-robin priority. It performs byte-lane alignment, store strobes, load sign/zero extension and misalignment detection. It sits between the pipeline's fetch/memory ports and the external bus.

## Interface
- `CHANNELS`, default 2: number of requesters; channel 0 is fetch, channel 1 is memory.
- `ADDR_WIDTH`, default 32: address width. Data is fixed at 32 bits.
- `ROUND_ROBIN`, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `req_address` in CHANNELS*ADDR_WIDTH: byte address per channel.
- `req_store_data` in CHANNELS*32: store data, right-aligned.
- `req_size` in CHANNELS*2: 0 byte, 1 half, 2 word, 3 reserved.
- `req_signed` in CHANNELS: sign-extend load.
- `req_load` in CHANNELS: load request.
- `req_store` in CHANNELS: store request.
- `req_ready` out CHANNELS: one-cycle completion pulse.
- `req_error` out CHANNELS: with `req_ready`, the access was rejected.
- `req_load_data` out 32: formatted load data, valid while any `req_ready` is high.
- `bus_address` out ADDR_WIDTH: word-aligned address (bits [1:0] = 0).
- `bus_write_data` out 32: lane-replicated store data.
- `bus_strobe` out 4: byte enables.
- `bus_write` out 1: 1 = store, 0 = load.
- `bus_valid` out 1: transaction request.
- `bus_ready` in 1: slave completion; `bus_read_data` is sampled in the same cycle.
- `bus_read_data` in 32: raw word from the bus.

## Operation
- A request on channel i is valid when `req_load[i] | req_store[i]`. The requester holds all request fields stable until it samples `req_ready[i]`.
- State machine with states IDLE, BUS, DONE.
  - IDLE: if any channel is valid, select a grant, latch that channel's fields, then branch:
    - Illegal request → DONE with error. Illegal means: size 3, load and store both set, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
    - Legal request → BUS.
  - BUS: `bus_valid`=1 with latched outputs. On `bus_ready`, capture formatted read data and go to DONE.
  - DONE: `req_ready[grant]`=1 (and `req_error[grant]` if error) for exactly one cycle, then IDLE. No new grant is made in DONE.
- Arbitration:
  - Fixed priority: the lowest valid index wins.
  - Round-robin: search from pointer `rr` upward, wrapping. On leaving DONE, `rr` ← (grant+1) mod CHANNELS. `rr` also advances after error completions.
- Store lanes, with off = `addr[1:0]`:
  - Byte: strobe = 1<<off; data = byte replicated ×4.
  - Half: strobe = 3<<off; data = half replicated ×2.
  - Word: strobe = 4'hF.
  - Loads: strobe is the same pattern as stores; `bus_write_data` = 0.
- Load format: shift `bus_read_data` right by off×8, mask to the access size, then sign-extend if `req_signed`, else zero-extend. For stores, `req_load_data` = 0.
- Error completions issue no bus cycle, and `req_load_data` = 0.

## Timing
- Reset value of every output is 0. State = IDLE, `rr` = 0, all latches cleared.
- Reset asserted mid-BUS abandons the transaction. `bus_valid` falls asynchronously; the slave must tolerate this.
- Latency, with the request seen in IDLE at cycle 0:
  - `bus_valid` is high from cycle 1.
  - `bus_ready` at cycle k (k≥1) gives `req_ready` at cycle k+1.
  - The minimum is 3 cycles per legal access; errors take 2.
- `bus_valid` and all bus outputs are registered and stable throughout BUS; they deassert in the cycle after `bus_ready`.
- `req_ready`/`req_error` are registered single-cycle pulses, at most one bit set. `req_load_data` is registered.
- Simultaneous events:
  - Requests from other channels arriving during BUS/DONE wait; they are never dropped or merged.
  - A requester dropping its request before ready is a protocol violation (unchecked).
- Round-robin with CHANNELS=1 degenerates to fixed priority.

## Structure
- `bus_pkg`: size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD, the state enum, and a function for strobe generation.
- Sub-module `bus_align` (combinational): load shift/extend and store replication, instantiated once. Arbitration and the FSM stay in `bus_arbiter`.

## Test plan
- Fixed priority: ch0 word load at 0x100 and ch1 byte store at 0x203 (data 0xAB) raised together. Required: ch0 served first; `bus_address`=0x100. Then ch1 with strobe 4'b1000, `bus_write_data`=0xABABABAB.
- Signed loads: `bus_read_data`=0x80FF7F01 with `bus_ready` at k=1.
  - Signed half at off 2 → 0xFFFF80FF.
  - Unsigned byte at off 1 → 0x0000007F.
  - `req_ready` at cycle 2.
- Round-robin, CHANNELS=3, all channels continuously requesting: grant order 0,1,2,0,… Each `req_ready` is one cycle, and there are never two in the same cycle.
- Misaligned word load at 0x102 → no `bus_valid`; `req_ready`+`req_error` at cycle 1; data 0.
- Stalled slave plus reset: `bus_ready` held low 10 cycles, then reset asserted mid-BUS. Required: all outputs 0 immediately; after release, IDLE with `rr`=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings, FSM states and lane helpers for the word-wide bus arbiter.
package bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << off;
      SIZE_HALF: strb = 4'b0011 << off;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Rejected without touching the bus: reserved size, dual op, or unaligned half/word.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off,
                                       input logic ld, input logic st);
    return (size == SIZE_RSVD) || (ld && st) ||
           ((size == SIZE_HALF) && off[0]) ||
           ((size == SIZE_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/bus_align.sv
// Combinational byte-lane steering: store replication and load shift/extend.
module bus_align
  import bus_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [31:0] write_data,
  output logic [31:0] load_data
);

  logic        [31:0] shifted;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign shifted = read_data >> {off, 3'b000};
  assign byte_s  = shifted[7:0];
  assign half_s  = shifted[15:0];

  always_comb begin
    write_data = store_data;
    load_data  = shifted;
    case (size)
      SIZE_BYTE: begin
        write_data = {4{store_data[7:0]}};
        load_data  = sign_ext ? 32'(byte_s) : {24'd0, shifted[7:0]};
      end
      SIZE_HALF: begin
        write_data = {2{store_data[15:0]}};
        load_data  = sign_ext ? 32'(half_s) : {16'd0, shifted[15:0]};
      end
      default: begin
        write_data = store_data;
        load_data  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates CHANNELS requesters onto one 32-bit system bus with lane alignment,
// misalignment rejection and fixed or round-robin priority.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] req_address,
  input  logic [CHANNELS*32-1:0]         req_store_data,
  input  logic [CHANNELS*2-1:0]          req_size,
  input  logic [CHANNELS-1:0]            req_signed,
  input  logic [CHANNELS-1:0]            req_load,
  input  logic [CHANNELS-1:0]            req_store,
  output logic [CHANNELS-1:0]            req_ready,
  output logic [CHANNELS-1:0]            req_error,
  output logic [31:0]                    req_load_data,
  output logic [ADDR_WIDTH-1:0]          bus_address,
  output logic [31:0]                    bus_write_data,
  output logic [3:0]                     bus_strobe,
  output logic                           bus_write,
  output logic                           bus_valid,
  input  logic                           bus_ready,
  input  logic [31:0]                    bus_read_data
);

  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr, start, grant, sel_idx;
  logic            sel_found;
  logic [CHANNELS-1:0] req_valid, grant_oh, sel_oh;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_sdata;
  logic [1:0]            sel_size;
  logic                  sel_signed, sel_load, sel_store, sel_bad;

  logic [1:0] lat_off, lat_size;
  logic       lat_signed, lat_load;

  logic [1:0]  al_off, al_size;
  logic        al_sign;
  logic [31:0] al_wdata, al_rdata;

  assign req_valid = req_load | req_store;
  assign start     = (ROUND_ROBIN != 0) ? rr : '0;

  // Rotating search from start; with fixed priority start is always 0.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(start) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!sel_found && req_valid[GW'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      grant_oh[i] = (GW'(i) == grant);
      sel_oh[i]   = (GW'(i) == sel_idx);
    end
  end

  assign sel_addr   = req_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_sdata  = req_store_data[sel_idx*32 +: 32];
  assign sel_size   = req_size[sel_idx*2 +: 2];
  assign sel_signed = req_signed[sel_idx];
  assign sel_load   = req_load[sel_idx];
  assign sel_store  = req_store[sel_idx];
  assign sel_bad    = req_illegal(sel_size, sel_addr[1:0], sel_load, sel_store);

  // The single aligner serves store replication at grant time and load formatting in BUS.
  assign al_off  = (state == IDLE) ? sel_addr[1:0] : lat_off;
  assign al_size = (state == IDLE) ? sel_size      : lat_size;
  assign al_sign = (state == IDLE) ? sel_signed    : lat_signed;

  bus_align u_align (
    .off        (al_off),
    .size       (al_size),
    .sign_ext   (al_sign),
    .store_data (sel_sdata),
    .read_data  (bus_read_data),
    .write_data (al_wdata),
    .load_data  (al_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = sel_bad ? DONE : BUS;
      BUS:     if (bus_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr             <= '0;
      grant          <= '0;
      lat_off        <= '0;
      lat_size       <= '0;
      lat_signed     <= 1'b0;
      lat_load       <= 1'b0;
      req_ready      <= '0;
      req_error      <= '0;
      req_load_data  <= '0;
      bus_address    <= '0;
      bus_write_data <= '0;
      bus_strobe     <= '0;
      bus_write      <= 1'b0;
      bus_valid      <= 1'b0;
    end else begin
      req_ready <= '0;
      req_error <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant      <= sel_idx;
            lat_off    <= sel_addr[1:0];
            lat_size   <= sel_size;
            lat_signed <= sel_signed;
            lat_load   <= sel_load;
            if (sel_bad) begin
              req_ready     <= sel_oh;
              req_error     <= sel_oh;
              req_load_data <= '0;
            end else begin
              bus_valid      <= 1'b1;
              bus_address    <= {sel_addr[ADDR_WIDTH-1:2], 2'b00};
              bus_write      <= sel_store;
              bus_strobe     <= lane_strobe(sel_size, sel_addr[1:0]);
              bus_write_data <= sel_store ? al_wdata : 32'd0;
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            bus_valid      <= 1'b0;
            bus_address    <= '0;
            bus_write      <= 1'b0;
            bus_strobe     <= '0;
            bus_write_data <= '0;
            req_ready      <= grant_oh;
            req_load_data  <= lat_load ? al_rdata : 32'd0;
          end
        end
        DONE: begin
          req_load_data <= '0;
          rr            <= (grant == GW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: table of single accesses on a 2-channel fixed arbiter, plus
// priority, round-robin and stall/reset sequences on a 3-channel round-robin arbiter.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Two-channel, fixed priority
  logic [63:0] req_address2, req_store_data2;
  logic [3:0]  req_size2;
  logic [1:0]  req_signed2, req_load2, req_store2, req_ready2, req_error2;
  logic [31:0] req_load_data2, bus_address2, bus_write_data2, bus_read_data2;
  logic [3:0]  bus_strobe2;
  logic        bus_write2, bus_valid2, bus_ready2;

  // Three-channel, round robin
  logic [95:0] req_address3, req_store_data3;
  logic [5:0]  req_size3;
  logic [2:0]  req_signed3, req_load3, req_store3, req_ready3, req_error3;
  logic [31:0] req_load_data3, bus_address3, bus_write_data3, bus_read_data3;
  logic [3:0]  bus_strobe3;
  logic        bus_write3, bus_valid3, bus_ready3;

  bus_arbiter #(.CHANNELS(2), .ADDR_WIDTH(32), .ROUND_ROBIN(0)) dut2 (
    .clk(clk), .reset(reset),
    .req_address(req_address2), .req_store_data(req_store_data2), .req_size(req_size2),
    .req_signed(req_signed2), .req_load(req_load2), .req_store(req_store2),
    .req_ready(req_ready2), .req_error(req_error2), .req_load_data(req_load_data2),
    .bus_address(bus_address2), .bus_write_data(bus_write_data2), .bus_strobe(bus_strobe2),
    .bus_write(bus_write2), .bus_valid(bus_valid2), .bus_ready(bus_ready2),
    .bus_read_data(bus_read_data2)
  );

  bus_arbiter #(.CHANNELS(3), .ADDR_WIDTH(32), .ROUND_ROBIN(1)) dut3 (
    .clk(clk), .reset(reset),
    .req_address(req_address3), .req_store_data(req_store_data3), .req_size(req_size3),
    .req_signed(req_signed3), .req_load(req_load3), .req_store(req_store3),
    .req_ready(req_ready3), .req_error(req_error3), .req_load_data(req_load_data3),
    .bus_address(bus_address3), .bus_write_data(bus_write_data3), .bus_strobe(bus_strobe3),
    .bus_write(bus_write3), .bus_valid(bus_valid3), .bus_ready(bus_ready3),
    .bus_read_data(bus_read_data3)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn, ld, st;
    logic [31:0] sd, rd;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_write;
    logic [31:0] e_ld;
    logic        e_err;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input int ch, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic ld, input logic st,
                              input logic [31:0] sd, input logic [31:0] rd,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input logic e_write,
                              input logic [31:0] e_ld, input logic e_err);
    vec_t v;
    v.ch = ch; v.addr = addr; v.size = size; v.sgn = sgn; v.ld = ld; v.st = st;
    v.sd = sd; v.rd = rd; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata;
    v.e_write = e_write; v.e_ld = e_ld; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic clear_req2();
    req_address2 = '0; req_store_data2 = '0; req_size2 = '0;
    req_signed2 = '0; req_load2 = '0; req_store2 = '0;
  endtask

  task automatic set_ch2(input int ch, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic ld, input logic st, input logic [31:0] sd);
    req_address2[ch*32 +: 32]    = addr;
    req_store_data2[ch*32 +: 32] = sd;
    req_size2[ch*2 +: 2]         = size;
    req_signed2[ch]              = sgn;
    req_load2[ch]                = ld;
    req_store2[ch]               = st;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.ch;
    @(negedge clk);
    set_ch2(v.ch, v.addr, v.size, v.sgn, v.ld, v.st, v.sd);
    bus_read_data2 = v.rd;
    @(negedge clk);
    if (v.e_err) begin
      chk($sformatf("v%0d_err_nobus", i), bus_valid2, 0);
      chk($sformatf("v%0d_err_ready", i), req_ready2, oh);
      chk($sformatf("v%0d_err_flag", i), req_error2, oh);
      chk($sformatf("v%0d_err_data", i), req_load_data2, 0);
      clear_req2();
      @(negedge clk);
      chk($sformatf("v%0d_err_pulse", i), {req_ready2, req_error2}, 0);
    end else begin
      chk($sformatf("v%0d_valid", i), bus_valid2, 1);
      chk($sformatf("v%0d_addr", i), bus_address2, v.e_addr);
      chk($sformatf("v%0d_strobe", i), bus_strobe2, v.e_strb);
      chk($sformatf("v%0d_wdata", i), bus_write_data2, v.e_wdata);
      chk($sformatf("v%0d_write", i), bus_write2, v.e_write);
      chk($sformatf("v%0d_early_ready", i), req_ready2, 0);
      bus_ready2 = 1'b1;
      @(negedge clk);
      bus_ready2 = 1'b0;
      clear_req2();
      chk($sformatf("v%0d_ready", i), req_ready2, oh);
      chk($sformatf("v%0d_noerr", i), req_error2, 0);
      chk($sformatf("v%0d_ldata", i), req_load_data2, v.e_ld);
      chk($sformatf("v%0d_valid_drop", i), bus_valid2, 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), req_ready2, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_gr, multi, wait_c;
    logic [2:0] prev;
    logic ok;

    clear_req2();
    bus_ready2 = 1'b0; bus_read_data2 = '0;
    req_address3 = '0; req_store_data3 = '0; req_size3 = 6'b101010;
    req_signed3 = '0; req_load3 = '0; req_store3 = '0;
    bus_ready3 = 1'b0; bus_read_data3 = 32'h5555AAAA;

    //        ch addr       sz    sg    ld    st    sd            rd            e_addr     strb   wdata         wr    ld_data       err
    vecs[0]  = mk(0, 32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 32'h100, 4'hF, 32'h0,        1'b0, 32'h12345678, 1'b0);
    vecs[1]  = mk(1, 32'h203, 2'd0, 1'b0, 1'b0, 1'b1, 32'h000000AB, 32'hFFFFFFFF, 32'h200, 4'h8, 32'hABABABAB, 1'b1, 32'h0,        1'b0);
    vecs[2]  = mk(0, 32'h102, 2'd1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h80FF7F01, 32'h100, 4'hC, 32'h0,        1'b0, 32'hFFFF80FF, 1'b0);
    vecs[3]  = mk(1, 32'h101, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80FF7F01, 32'h100, 4'h2, 32'h0,        1'b0, 32'h0000007F, 1'b0);
    vecs[4]  = mk(0, 32'h203, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h80FF7F01, 32'h200, 4'h8, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0);
    vecs[5]  = mk(1, 32'h302, 2'd1, 1'b0, 1'b0, 1'b1, 32'h1234BEEF, 32'hFFFFFFFF, 32'h300, 4'hC, 32'hBEEFBEEF, 1'b1, 32'h0,        1'b0);
    vecs[6]  = mk(0, 32'h100, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h80FF7F01, 32'h100, 4'h3, 32'h0,        1'b0, 32'h00007F01, 1'b0);
    vecs[7]  = mk(1, 32'h40C, 2'd2, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h40C, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0);
    vecs[8]  = mk(0, 32'h100, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h80FF7F01, 32'h100, 4'h1, 32'h0,        1'b0, 32'h00000001, 1'b0);
    vecs[9]  = mk(0, 32'h102, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 32'h0,   4'h0, 32'h0,        1'b0, 32'h0,        1'b1);
    vecs[10] = mk(1, 32'h301, 2'd1, 1'b0, 1'b0, 1'b1, 32'h1234,     32'h12345678, 32'h0,   4'h0, 32'h0,        1'b0, 32'h0,        1'b1);
    vecs[11] = mk(0, 32'h100, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 32'h0,   4'h0, 32'h0,        1'b0, 32'h0,        1'b1);
    vecs[12] = mk(1, 32'h100, 2'd2, 1'b0, 1'b1, 1'b1, 32'h55,       32'h12345678, 32'h0,   4'h0, 32'h0,        1'b0, 32'h0,        1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {bus_valid2, bus_valid3}, 0);
    chk("rst_ready", {req_ready2, req_ready3, req_error2, req_error3}, 0);
    chk("rst_addr", bus_address2 | bus_address3, 0);
    chk("rst_bus", {bus_strobe2, bus_strobe3, bus_write2, bus_write3}, 0);
    chk("rst_data", req_load_data2 | req_load_data3 | bus_write_data2 | bus_write_data3, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Fixed priority: both channels raised together, ch0 first
    @(negedge clk);
    set_ch2(0, 32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
    set_ch2(1, 32'h203, 2'd0, 1'b0, 1'b0, 1'b1, 32'h000000AB);
    bus_read_data2 = 32'hCAFEF00D;
    @(negedge clk);
    chk("prio_first_addr", bus_address2, 32'h100);
    chk("prio_first_write", bus_write2, 0);
    bus_ready2 = 1'b1;
    @(negedge clk);
    bus_ready2 = 1'b0;
    chk("prio_first_ready", req_ready2, 2'b01);
    chk("prio_first_data", req_load_data2, 32'hCAFEF00D);
    set_ch2(0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_c = 0;
    while (!bus_valid2 && wait_c < 10) begin
      @(negedge clk);
      wait_c++;
    end
    chk("prio_second_valid", bus_valid2, 1);
    chk("prio_second_addr", bus_address2, 32'h200);
    chk("prio_second_strobe", bus_strobe2, 4'b1000);
    chk("prio_second_wdata", bus_write_data2, 32'hABABABAB);
    bus_ready2 = 1'b1;
    @(negedge clk);
    bus_ready2 = 1'b0;
    chk("prio_second_ready", req_ready2, 2'b10);
    clear_req2();

    // Round robin with all three channels continuously requesting
    @(negedge clk);
    req_address3 = {32'h3000, 32'h2000, 32'h1000};
    req_load3 = 3'b111;
    bus_ready3 = 1'b1;
    n_gr = 0; multi = 0; prev = '0;
    for (int c = 0; c < 60 && n_gr < 7; c++) begin
      @(negedge clk);
      if ($countones(req_ready3) > 1) multi++;
      if (req_ready3 != 3'b000) begin
        chk($sformatf("rr_order%0d", n_gr), req_ready3, 3'b001 << (n_gr % 3));
        chk($sformatf("rr_pulse%0d", n_gr), prev, 0);
        n_gr++;
      end
      prev = req_ready3;
    end
    chk("rr_grant_count", n_gr, 7);
    chk("rr_single_bit", multi, 0);

    // Stalled slave: only ch1 left; rr now points at 1
    bus_ready3 = 1'b0;
    req_load3 = 3'b010;
    repeat (2) @(negedge clk);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!(bus_valid3 === 1'b1 && bus_address3 === 32'h2000 && req_ready3 === 3'b000)) ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_hold", ok, 1);
    reset = 1'b1;
    #1;
    chk("midbus_rst_valid", bus_valid3, 0);
    chk("midbus_rst_outs", {bus_address3, bus_strobe3, bus_write3, req_ready3, req_error3}, 0);
    chk("midbus_rst_data", req_load_data3 | bus_write_data3, 0);
    req_load3 = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {bus_valid3, req_ready3}, 0);
    req_load3 = 3'b111;
    bus_ready3 = 1'b1;
    @(negedge clk);
    chk("post_rst_rr_valid", bus_valid3, 1);
    chk("post_rst_rr_addr", bus_address3, 32'h1000);
    req_load3 = 3'b000;
    @(negedge clk);
    chk("post_rst_rr_ready", req_ready3, 3'b001);
    bus_ready3 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
